seq_signed_mult: RTL
====================

# seq_signed_mult

Sequential multiplier with per-operation signed/unsigned mode. Operands are accepted through a valid/ready handshake. The product is formed by an iterative shift-add over the multiplier operand and returned through a second valid/ready handshake. It replaces the combinational multiplier in datapaths where area matters more than latency. The partial-product width per cycle is a parameter, so one RTL covers designs from bit-serial to wide-digit.

## Interface
- `A_WIDTH`, 8: multiplicand width (bits), ≥2
- `B_WIDTH`, 8: multiplier width (bits), ≥2
- `BITS_PER_CYC`, 1: multiplier bits consumed per compute cycle; must divide `B_WIDTH` exactly
- `PRODUCT_WIDTH`, `A_WIDTH+B_WIDTH`: localparam, not overridable
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_vld`  in  1  operand valid
- `in_rdy`  out  1  block can accept operands
- `dat_a`  in  `A_WIDTH`  multiplicand
- `dat_b`  in  `B_WIDTH`  multiplier
- `tc`  in  1  0: unsigned operands, 1: two's-complement operands; sampled with the operands
- `out_vld`  out  1  product valid
- `out_rdy`  in  1  downstream accepts product
- `product`  out  `PRODUCT_WIDTH`  result; unsigned or two's-complement per latched `tc`

## Operation
- Define N = `B_WIDTH`/`BITS_PER_CYC`.
- States:
  - IDLE: `in_rdy`=1.
  - CALC: shift-add over N cycles.
  - DONE: `out_vld`=1.
- IDLE → CALC on `in_vld & in_rdy`. On that edge the block latches:
  - `tc`.
  - Operand sign bits.
  - Magnitudes |a| and |b|: the two's-complement negation when `tc`=1 and the MSB is set, otherwise the raw value.
- Magnitudes are treated as unsigned `A_WIDTH`/`B_WIDTH` values. The most negative input (e.g. 0x80) therefore yields magnitude 0x80, which is correct.
- CALC, each cycle:
  - acc += |a| × (the low `BITS_PER_CYC` bits of the B shift register), shifted into position.
  - The B register shifts right by `BITS_PER_CYC`.
  - The iteration counter increments.
  - Accumulator width is `PRODUCT_WIDTH`; no overflow is possible.
- CALC → DONE after exactly N cycles. On the transition, the product register loads:
  - −acc (modulo 2^`PRODUCT_WIDTH`) if latched `tc`=1 and sign_a XOR sign_b;
  - acc otherwise.
- DONE → IDLE on `out_vld & out_rdy`.
- `product` holds stable and `out_vld` stays high while `out_rdy`=0. Backpressure is unbounded.
- `in_vld` is ignored outside IDLE, and operand inputs may change freely after acceptance.
- A zero operand still takes the full N cycles; there is no early termination.
- Reset (`rst_n`=0, any state, including mid-CALC or DONE):
  - State → IDLE.
  - Accumulator, counter, shift registers, `product` → 0.
  - `out_vld` → 0.
  - The in-flight operation is discarded; no product is emitted for it.
  - `in_rdy` = (state==IDLE), so it reads 1 during and after reset.

## Timing
- Cycle T: input handshake.
- Cycles T+1 … T+N: CALC.
- Cycle T+N+1: `out_vld`=1 with final `product`. Latency is N+1 cycles from input handshake to `out_vld`.
- Output handshake at cycle U ⇒ `in_rdy`=1 at U+1.
  - The earliest next input handshake is U+1.
  - Minimum initiation interval is N+2 cycles.
- No combinational path from `in_vld` to `in_rdy` or from `out_rdy` to `out_vld`. All outputs except `in_rdy` are registered; `in_rdy` is decoded from the state register only.
- Reset takes effect asynchronously and is released synchronously to `clk` (external reset synchroniser). The first handshake is legal on the first rising edge with `rst_n`=1.

## Test plan
- 8×8, `BITS_PER_CYC`=1, `tc`=1, a=0xFD (−3), b=0x05 ⇒ `out_vld` exactly 9 cycles after accept, `product`=0xFFF1. Same operands with `tc`=0 ⇒ 0x04F1.
- Corner signed cases:
  - `tc`=1, a=0x80, b=0x80 ⇒ 0x4000.
  - a=0x80, b=0x7F ⇒ 0xC080.
  - a=0x00, b=0x80 ⇒ 0x0000 (no −0 artefact).
- Unsigned maximum: `tc`=0, a=0xFF, b=0xFF ⇒ 0xFE01. Repeat with `BITS_PER_CYC`=2, 4 and 8:
  - `out_vld` latency 5, 3 and 2 cycles respectively;
  - identical product.
- Backpressure: hold `out_rdy`=0 for 6 cycles after `out_vld` ⇒ `product`, `out_vld` stable, `in_rdy`=0, `in_vld` pulses ignored. Then release:
  - `in_rdy`=1 the cycle after the handshake;
  - back-to-back operations at II = N+2.
- Reset mid-operation: assert `rst_n`=0 at cycle T+3 of a CALC ⇒ `out_vld`=0 and `product`=0 immediately; no stale output after release. The next operation (a=0x07, b=0xF9, `tc`=1) yields 0xFFCF.
- Random regression: 10k operations, random widths/`BITS_PER_CYC` configs, random `tc`, random `in_vld`/`out_rdy` gaps ⇒ every product matches the reference model, with no lost or duplicated results.

Source files
------------

// File: rtl/seq_signed_mult.sv
// rtl/seq_signed_mult.sv - iterative shift-add multiplier with per-operation signed/unsigned mode
//
// Operands are accepted when in_vld & in_rdy. The block then spends exactly
// B_WIDTH/BITS_PER_CYC cycles accumulating |a| * |b| one multiplier digit at a
// time. The sign is applied once at the end, and the product is held with
// out_vld until out_rdy.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   in_vld   in   operand valid
//   in_rdy   out  block can accept operands (decoded from state only)
//   dat_a    in   multiplicand, A_WIDTH bits
//   dat_b    in   multiplier, B_WIDTH bits
//   tc       in   0: unsigned operands, 1: two's-complement operands
//   out_vld  out  product valid (registered)
//   out_rdy  in   downstream accepts product
//   product  out  A_WIDTH+B_WIDTH result (registered)

module seq_signed_mult #(
    parameter int A_WIDTH       = 8,
    parameter int B_WIDTH       = 8,
    parameter int BITS_PER_CYC  = 1,
    localparam int PRODUCT_WIDTH = A_WIDTH + B_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic [A_WIDTH-1:0]       dat_a,
    input  logic [B_WIDTH-1:0]       dat_b,
    input  logic                     tc,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [PRODUCT_WIDTH-1:0] product
);

    localparam int N     = B_WIDTH / BITS_PER_CYC;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t                   state;
    logic                     tc_q;
    logic                     sign_a;
    logic                     sign_b;
    // |a| pre-shifted to the weight of the digit currently at the bottom of b_sh,
    // so each step adds a plain product with no variable shifter.
    logic [PRODUCT_WIDTH-1:0] a_sh;
    logic [B_WIDTH-1:0]       b_sh;
    logic [PRODUCT_WIDTH-1:0] acc;
    logic [CNT_W-1:0]         cnt;

    logic                     neg_a_in;
    logic                     neg_b_in;
    logic [A_WIDTH-1:0]       mag_a_in;
    logic [B_WIDTH-1:0]       mag_b_in;
    logic [PRODUCT_WIDTH-1:0] digit;
    logic [PRODUCT_WIDTH-1:0] partial;
    logic [PRODUCT_WIDTH-1:0] acc_next;
    logic [PRODUCT_WIDTH-1:0] result;
    logic [B_WIDTH-1:0]       b_next;

    assign in_rdy = (state == S_IDLE);

    always_comb begin
        neg_a_in = tc & dat_a[A_WIDTH-1];
        neg_b_in = tc & dat_b[B_WIDTH-1];
        // Magnitudes are unsigned: the most negative input negates to itself,
        // which is its correct unsigned magnitude.
        mag_a_in = neg_a_in ? (A_WIDTH'(0) - dat_a) : dat_a;
        mag_b_in = neg_b_in ? (B_WIDTH'(0) - dat_b) : dat_b;
        digit    = PRODUCT_WIDTH'(b_sh[BITS_PER_CYC-1:0]);
        partial  = a_sh * digit;
        acc_next = acc + partial;
        // A zero magnitude negates to zero, so no -0 artefact can appear.
        result   = (tc_q & (sign_a ^ sign_b)) ? (PRODUCT_WIDTH'(0) - acc_next) : acc_next;
    end

    // When one digit spans the whole multiplier, the register simply empties.
    if (BITS_PER_CYC < B_WIDTH) begin : g_shift
        assign b_next = {{BITS_PER_CYC{1'b0}}, b_sh[B_WIDTH-1:BITS_PER_CYC]};
    end else begin : g_whole
        assign b_next = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            tc_q    <= 1'b0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
            out_vld <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_vld) begin
                        tc_q   <= tc;
                        sign_a <= dat_a[A_WIDTH-1];
                        sign_b <= dat_b[B_WIDTH-1];
                        a_sh   <= PRODUCT_WIDTH'(mag_a_in);
                        b_sh   <= mag_b_in;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc  <= acc_next;
                    a_sh <= a_sh << BITS_PER_CYC;
                    b_sh <= b_next;
                    cnt  <= cnt + 1'b1;
                    // Always the full digit count; zero operands are not short-cut.
                    if (cnt == LAST_CNT) begin
                        product <= result;
                        out_vld <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_rdy) begin
                        out_vld <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
